// File: rtl/aquila_dbus_router_if.sv
// Data-bus bundle between the Aquila core data port and the router's target ports.
// The router takes the slave view; the environment (core plus targets) takes the master view.
interface aquila_dbus_router_if #(
  parameter int XLEN  = 32,
  parameter int N_SLV = 4
);
  // core side
  logic                      c_strobe;
  logic [XLEN-1:0]           c_addr;
  logic                      c_rw;
  logic [XLEN/8-1:0]         c_byte_enable;
  logic [XLEN-1:0]           c_wdata;
  logic [XLEN-1:0]           c_rdata;
  logic                      c_ready;
  logic                      c_err;
  logic                      c_busy;
  // target side, slice k belongs to slave k
  logic [N_SLV-1:0]          s_strobe;
  logic [N_SLV*XLEN-1:0]     s_addr;
  logic [N_SLV-1:0]          s_rw;
  logic [N_SLV*XLEN/8-1:0]   s_byte_enable;
  logic [N_SLV*XLEN-1:0]     s_wdata;
  logic [N_SLV-1:0]          s_ready;
  logic [N_SLV*XLEN-1:0]     s_rdata;

  modport slave (
    input  c_strobe, c_addr, c_rw, c_byte_enable, c_wdata,
    output c_rdata, c_ready, c_err, c_busy,
    output s_strobe, s_addr, s_rw, s_byte_enable, s_wdata,
    input  s_ready, s_rdata
  );

  modport master (
    output c_strobe, c_addr, c_rw, c_byte_enable, c_wdata,
    input  c_rdata, c_ready, c_err, c_busy,
    input  s_strobe, s_addr, s_rw, s_byte_enable, s_wdata,
    output s_ready, s_rdata
  );
endinterface

// File: rtl/aquila_dbus_router.sv
// Region-table data-bus router: decodes the top address bits to one of N_SLV targets,
// holds the selection for the whole transaction and answers with a bus error on miss or timeout.
module aquila_dbus_router #(
  parameter int                             XLEN           = 32,
  parameter int                             N_SLV          = 4,
  parameter int                             REGION_BITS    = 4,
  parameter logic [N_SLV*REGION_BITS-1:0]   SLV_TAG        = {4'hF, 4'hC, 4'h8, 4'h0},
  parameter int                             DEFAULT_SLV    = 1,
  parameter int                             TIMEOUT_CYCLES = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  aquila_dbus_router_if.slave bus,
  output logic [XLEN-1:0]     err_addr_o,
  output logic [7:0]          err_cnt_o
);
  localparam int SEL_W = $clog2(N_SLV + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [SEL_W-1:0] SEL_NONE = SEL_W'(N_SLV);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR} state_t;

  state_t            state_reg;
  logic [SEL_W-1:0]  sel_reg;
  logic [TMO_W-1:0]  tmo_cnt_reg;
  logic [XLEN-1:0]   req_addr_reg;
  logic [XLEN-1:0]   err_addr_reg;
  logic [7:0]        err_cnt_reg;
  logic [7:0]        err_cnt_next;

  logic [N_SLV-1:0]  hit;
  logic [SEL_W-1:0]  tgt;
  logic [SEL_W-1:0]  route;
  logic              tgt_valid;
  logic              issue;
  logic              sel_ready;
  logic [XLEN-1:0]   sel_rdata;
  logic              tmo_hit;

  generate
    for (genvar gi = 0; gi < N_SLV; gi++) begin : g_hit
      assign hit[gi] = (bus.c_addr[XLEN-1 -: REGION_BITS] == SLV_TAG[gi*REGION_BITS +: REGION_BITS]);
    end
  endgenerate

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    tgt = SEL_W'(DEFAULT_SLV);
    for (int k = N_SLV - 1; k >= 0; k--) begin
      if (hit[k]) tgt = SEL_W'(k);
    end
  end

  assign tgt_valid = (tgt < SEL_NONE);
  assign issue     = !rst_i && (state_reg == S_IDLE) && bus.c_strobe && tgt_valid;
  assign route     = issue ? tgt : ((!rst_i && state_reg == S_WAIT) ? sel_reg : SEL_NONE);

  // Only the routed target sees live core fields; all others are held at zero.
  generate
    for (genvar gi = 0; gi < N_SLV; gi++) begin : g_slv
      logic fwd;
      assign fwd                                              = (route == SEL_W'(gi));
      assign bus.s_strobe[gi]                                 = issue && (tgt == SEL_W'(gi));
      assign bus.s_rw[gi]                                     = bus.s_strobe[gi] && bus.c_rw;
      assign bus.s_addr[gi*XLEN +: XLEN]                      = fwd ? bus.c_addr : '0;
      assign bus.s_wdata[gi*XLEN +: XLEN]                     = fwd ? bus.c_wdata : '0;
      assign bus.s_byte_enable[gi*(XLEN/8) +: (XLEN/8)]       = fwd ? bus.c_byte_enable : '0;
    end
  endgenerate

  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < N_SLV; k++) begin
      if (sel_reg == SEL_W'(k)) begin
        sel_ready = bus.s_ready[k];
        sel_rdata = bus.s_rdata[k*XLEN +: XLEN];
      end
    end
  end

  assign tmo_hit      = (tmo_cnt_reg == TMO_LAST);
  assign err_cnt_next = (err_cnt_reg == 8'hFF) ? err_cnt_reg : err_cnt_reg + 8'd1;

  // A ready landing in the timeout cycle still completes the transaction cleanly.
  always_comb begin
    bus.c_ready = 1'b0;
    bus.c_err   = 1'b0;
    bus.c_rdata = '0;
    if (!rst_i) begin
      unique case (state_reg)
        S_WAIT: begin
          bus.c_ready = sel_ready || tmo_hit;
          bus.c_err   = !sel_ready && tmo_hit;
          bus.c_rdata = (!sel_ready && tmo_hit) ? '0 : sel_rdata;
        end
        S_ERR: begin
          bus.c_ready = 1'b1;
          bus.c_err   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.c_busy = !rst_i && ((state_reg != S_IDLE) || bus.c_strobe);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= S_IDLE;
      sel_reg      <= '0;
      tmo_cnt_reg  <= '0;
      req_addr_reg <= '0;
      err_addr_reg <= '0;
      err_cnt_reg  <= '0;
    end else begin
      unique case (state_reg)
        S_IDLE: begin
          if (bus.c_strobe) begin
            req_addr_reg <= bus.c_addr;
            tmo_cnt_reg  <= '0;
            if (tgt_valid) begin
              sel_reg   <= tgt;
              state_reg <= S_WAIT;
            end else begin
              err_addr_reg <= bus.c_addr;
              state_reg    <= S_ERR;
            end
          end
        end
        S_WAIT: begin
          if (sel_ready) begin
            state_reg <= S_IDLE;
          end else if (tmo_hit) begin
            state_reg    <= S_IDLE;
            err_addr_reg <= req_addr_reg;
            err_cnt_reg  <= err_cnt_next;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
          end
        end
        S_ERR: begin
          state_reg   <= S_IDLE;
          err_cnt_reg <= err_cnt_next;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign err_addr_o = err_addr_reg;
  assign err_cnt_o  = err_cnt_reg;
endmodule

// File: tb/tb_aquila_dbus_router.sv
// Scoreboard bench: two routers (default slave 1, and no default slave) share one core stimulus stream.
module tb_aquila_dbus_router;
  localparam int          TMO  = 8;
  localparam logic [15:0] TAGS = {4'h0, 4'hC, 4'hF, 4'hE};   // slave3=0, slave2=C, slave1=F, slave0=E

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          cyc;
    logic [7:0]  cnt;
    logic [31:0] eaddr;
  } resp_t;

  typedef struct {
    logic [3:0]   strobe;
    logic [3:0]   rw;
    logic [127:0] addr;
    logic [15:0]  be;
    logic [127:0] wdata;
  } sreq_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        c_strobe;
  logic [31:0] c_addr;
  logic        c_rw;
  logic [3:0]  c_be;
  logic [31:0] c_wdata;
  logic [3:0]  stray_ready;
  int          cur_lat;
  logic [31:0] cur_rdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  resp_t       resp_q [2][$];
  sreq_t       sreq_q [2][$];
  logic [7:0]  exp_cnt [2];
  logic [31:0] exp_eaddr [2];

  logic         mon_ready [2];
  logic         mon_err [2];
  logic         mon_busy [2];
  logic [31:0]  mon_rdata [2];
  logic [3:0]   mon_sstb [2];
  logic [3:0]   mon_srw [2];
  logic [127:0] mon_saddr [2];
  logic [127:0] mon_swdata [2];
  logic [15:0]  mon_sbe [2];
  logic [31:0]  mon_eaddr [2];
  logic [7:0]   mon_ecnt [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
      aquila_dbus_router_if #(.XLEN(32), .N_SLV(4)) bus ();
      logic [3:0]   rsp_ready;
      logic [127:0] rsp_rdata;

      assign bus.c_strobe      = c_strobe;
      assign bus.c_addr        = c_addr;
      assign bus.c_rw          = c_rw;
      assign bus.c_byte_enable = c_be;
      assign bus.c_wdata       = c_wdata;
      assign bus.s_ready       = rsp_ready | stray_ready;
      assign bus.s_rdata       = rsp_rdata;

      assign mon_ready[gi]  = bus.c_ready;
      assign mon_err[gi]    = bus.c_err;
      assign mon_busy[gi]   = bus.c_busy;
      assign mon_rdata[gi]  = bus.c_rdata;
      assign mon_sstb[gi]   = bus.s_strobe;
      assign mon_srw[gi]    = bus.s_rw;
      assign mon_saddr[gi]  = bus.s_addr;
      assign mon_swdata[gi] = bus.s_wdata;
      assign mon_sbe[gi]    = bus.s_byte_enable;

      aquila_dbus_router #(
        .XLEN(32), .N_SLV(4), .REGION_BITS(4), .SLV_TAG(TAGS),
        .DEFAULT_SLV(gi == 0 ? 1 : 4), .TIMEOUT_CYCLES(TMO)
      ) u_dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus        (bus),
        .err_addr_o (mon_eaddr[gi]),
        .err_cnt_o  (mon_ecnt[gi])
      );

      // Target model: answers the strobed slave cur_lat cycles later, or never if beyond the timeout.
      initial begin
        int k;
        int lat;
        logic [31:0] d;
        rsp_ready = '0;
        rsp_rdata = '0;
        forever begin
          @(negedge clk);
          if (!rst && bus.s_strobe != 4'b0) begin
            k = 0;
            for (int j = 0; j < 4; j++) if (bus.s_strobe[j]) k = j;
            lat = cur_lat;
            d   = cur_rdata;
            if (lat <= TMO) begin
              repeat (lat) @(posedge clk);
              #1;
              rsp_ready[k] = 1'b1;
              rsp_rdata[k*32 +: 32] = d;
              @(posedge clk);
              #1;
              rsp_ready = '0;
              rsp_rdata = '0;
            end
          end
        end
      end
    end
  endgenerate

  function automatic void chk(string name, int inst, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d cyc=%0d: got %0h, expected %0h", name, inst, cyc, act, exp);
    end
  endfunction

  // Region map from the tag table; unmatched addresses go to the instance's default (4 = none).
  function automatic int model_target(logic [31:0] addr, int inst);
    case (addr[31:28])
      4'hE:    return 0;
      4'hF:    return 1;
      4'hC:    return 2;
      4'h0:    return 3;
      default: return (inst == 0) ? 1 : 4;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc(logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  task automatic issue(input logic [31:0] addr, input logic rw, input logic [3:0] be,
                       input logic [31:0] wdata, input int lat, input logic [31:0] rdata,
                       input bit expect_resp);
    resp_t r;
    sreq_t s;
    int    t;
    @(posedge clk);
    #1;
    c_strobe = 1'b1; c_addr = addr; c_rw = rw; c_be = be; c_wdata = wdata;
    cur_lat = lat; cur_rdata = rdata;
    for (int i = 0; i < 2; i++) begin
      t = model_target(addr, i);
      if (t == 4) begin
        exp_cnt[i]   = sat_inc(exp_cnt[i]);
        exp_eaddr[i] = addr;
        r.err = 1'b1; r.data = 32'h0; r.cyc = cyc + 1;
      end else begin
        s.strobe = 4'b0001 << t;
        s.rw     = rw ? s.strobe : 4'b0000;
        s.addr   = 128'(addr) << (32 * t);
        s.be     = 16'(be) << (4 * t);
        s.wdata  = 128'(wdata) << (32 * t);
        sreq_q[i].push_back(s);
        if (lat <= TMO) begin
          r.err = 1'b0; r.data = rdata; r.cyc = cyc + lat;
        end else begin
          exp_cnt[i]   = sat_inc(exp_cnt[i]);
          exp_eaddr[i] = addr;
          r.err = 1'b1; r.data = 32'h0; r.cyc = cyc + TMO;
        end
      end
      r.cnt   = exp_cnt[i];
      r.eaddr = exp_eaddr[i];
      if (expect_resp) resp_q[i].push_back(r);
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk("busy_on_strobe", i, 128'(mon_busy[i]), 128'(1));
    @(posedge clk);
    #1;
    c_strobe = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (!mon_busy[0] && !mon_busy[1]) done = 1;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_wait cyc=%0d: got busy after 40 cycles, expected idle", cyc);
    end
  endtask

  // Monitor: pops an expectation whenever a router answers the core or strobes a target.
  initial begin
    resp_t r;
    sreq_t s;
    resp_t pend_r [2];
    bit    pend [2];
    pend[0] = 0;
    pend[1] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (pend[i]) begin
          chk("err_cnt", i, 128'(mon_ecnt[i]), 128'(pend_r[i].cnt));
          chk("err_addr", i, 128'(mon_eaddr[i]), 128'(pend_r[i].eaddr));
          pend[i] = 0;
        end
        if (mon_ready[i]) begin
          if (resp_q[i].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_ready inst%0d cyc=%0d: got ready=1, expected ready=0", i, cyc);
          end else begin
            r = resp_q[i].pop_front();
            $display("resp inst%0d cyc=%0d err=%0b data=%08h", i, cyc, mon_err[i], mon_rdata[i]);
            chk("ready_cycle", i, 128'(cyc), 128'(r.cyc));
            chk("c_err", i, 128'(mon_err[i]), 128'(r.err));
            chk("c_rdata", i, 128'(mon_rdata[i]), 128'(r.data));
            pend[i]   = 1;
            pend_r[i] = r;
          end
        end
        if (mon_sstb[i] != 4'b0) begin
          if (sreq_q[i].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_strobe inst%0d cyc=%0d: got s_strobe=%0b, expected none", i, cyc, mon_sstb[i]);
          end else begin
            s = sreq_q[i].pop_front();
            chk("s_strobe", i, 128'(mon_sstb[i]), 128'(s.strobe));
            chk("s_rw", i, 128'(mon_srw[i]), 128'(s.rw));
            chk("s_addr", i, mon_saddr[i], s.addr);
            chk("s_be", i, 128'(mon_sbe[i]), 128'(s.be));
            chk("s_wdata", i, mon_swdata[i], s.wdata);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] tag;
    rst = 1'b1; c_strobe = 1'b0; c_addr = '0; c_rw = 1'b0; c_be = '0; c_wdata = '0;
    stray_ready = '0; cur_lat = 0; cur_rdata = '0;
    exp_cnt[0] = '0; exp_cnt[1] = '0; exp_eaddr[0] = '0; exp_eaddr[1] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", i, 128'(mon_ready[i]), 128'(0));
      chk("rst_err", i, 128'(mon_err[i]), 128'(0));
      chk("rst_busy", i, 128'(mon_busy[i]), 128'(0));
      chk("rst_sstb", i, 128'(mon_sstb[i]), 128'(0));
      chk("rst_ecnt", i, 128'(mon_ecnt[i]), 128'(0));
      chk("rst_eaddr", i, 128'(mon_eaddr[i]), 128'(0));
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    issue(32'h0000_0010, 1'b0, 4'hF, 32'h0, 2, 32'hDEAD_BEEF, 1); wait_idle();
    issue(32'h8000_0004, 1'b1, 4'b0011, 32'h0000_1234, 3, 32'h0, 1); wait_idle();
    issue(32'h5000_0000, 1'b0, 4'hF, 32'h0, 1, 32'h5555_AAAA, 1); wait_idle();
    issue(32'hC000_0000, 1'b0, 4'hF, 32'h0, 99, 32'h1111_2222, 1); wait_idle();
    issue(32'hC000_0000, 1'b0, 4'hF, 32'h0, TMO, 32'hCAFE_F00D, 1); wait_idle();
    issue(32'hE000_0100, 1'b1, 4'b1000, 32'hA5A5_0000, 1, 32'h0BAD_CAFE, 1); wait_idle();

    // Dropped second strobe, then a stray ready from slave 0 while slave 2 is selected.
    issue(32'hC000_0040, 1'b0, 4'hF, 32'h0, 6, 32'h600D_D00D, 1);
    c_strobe = 1'b1; c_addr = 32'h0000_0010;
    @(posedge clk); #1;
    c_strobe = 1'b0; stray_ready = 4'b0001;
    @(posedge clk); #1;
    stray_ready = 4'b0000;
    wait_idle();

    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 6))
        0:       tag = 4'hE;
        1:       tag = 4'hF;
        2:       tag = 4'hC;
        3:       tag = 4'h0;
        4:       tag = 4'h8;
        5:       tag = 4'h5;
        default: tag = 4'($urandom);
      endcase
      issue({tag, 28'($urandom)}, 1'($urandom), 4'($urandom), $urandom,
            $urandom_range(1, TMO + 2), $urandom, 1);
      wait_idle();
    end

    // Reset while waiting on a slave; a late ready after reset must not complete anything.
    issue(32'hC000_0000, 1'b0, 4'hF, 32'h0, 99, 32'h0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; stray_ready = 4'b0100;
    @(posedge clk); #1;
    stray_ready = 4'b0000;
    repeat (3) @(negedge clk);
    exp_cnt[0] = '0; exp_cnt[1] = '0; exp_eaddr[0] = '0; exp_eaddr[1] = '0;
    for (int i = 0; i < 2; i++) begin
      chk("post_rst_busy", i, 128'(mon_busy[i]), 128'(0));
      chk("post_rst_ecnt", i, 128'(mon_ecnt[i]), 128'(0));
      chk("post_rst_eaddr", i, 128'(mon_eaddr[i]), 128'(0));
    end

    for (int n = 0; n < 300; n++) begin
      issue(32'hC000_0000 + 32'(n * 4), 1'b0, 4'hF, 32'h0, 99, 32'h0, 1);
      wait_idle();
    end
    issue(32'h7000_0000, 1'b0, 4'hF, 32'h0, 2, 32'h7777_7777, 1); wait_idle();
    for (int i = 0; i < 2; i++) chk("err_cnt_sat", i, 128'(mon_ecnt[i]), 128'(8'd255));

    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("resp_q_left", i, 128'(resp_q[i].size()), 128'(0));
      chk("sreq_q_left", i, 128'(sreq_q[i].size()), 128'(0));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
